// File: rtl/ram_pkg.sv
// Shared types and helpers for the pipelined dual-port RAM.
package ram_pkg;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int RD_LAT_MAX = 2;

  // Even parity: the stored bit makes byte+parity carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/pipelined_dp_ram_if.sv
// Request/response bundle for pipelined_dp_ram: port A read/write, port B read-only.
// Parity error outputs exist only when RAM_PARITY_EN is defined.
interface pipelined_dp_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  localparam int NB = DATA_W / 8;

  logic              a_valid;
  logic              a_ready;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [NB-1:0]     a_be;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic              init_done;
`ifdef RAM_PARITY_EN
  logic              a_perr;
  logic              b_perr;
`endif

  modport master (
    output a_valid, a_we, a_addr, a_wdata, a_be, b_valid, b_addr,
    input  a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata, init_done
`ifdef RAM_PARITY_EN
    , input a_perr, b_perr
`endif
  );

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata, a_be, b_valid, b_addr,
    output a_ready, a_rvalid, a_rdata, b_ready, b_rvalid, b_rdata, init_done
`ifdef RAM_PARITY_EN
    , output a_perr, b_perr
`endif
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// Read response delay line: LAT (1 or 2) register stages for valid and data.
// Data registers load only with a valid, so the output holds its last value between responses.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);

  logic         v1;
  logic [W-1:0] d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= in_vld;
      if (in_vld) d1 <= in_dat;
    end
  end

  generate
    if (LAT >= RD_LAT_MAX) begin : g_two
      logic         v2;
      logic [W-1:0] d2;

      always_ff @(posedge clk) begin
        if (reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign out_vld = v2;
      assign out_dat = d2;
    end else begin : g_one
      assign out_vld = v1;
      assign out_dat = d1;
    end
  endgenerate

endmodule

// File: rtl/pipelined_dp_ram.sv
// Dual-port word RAM, cleared after reset (ports stall until done), RD_LAT-cycle read responses.
// Optional per-byte even parity with read-side checking when RAM_PARITY_EN is defined.
module pipelined_dp_ram
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  pipelined_dp_ram_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
`ifdef RAM_PARITY_EN
  localparam int PW    = DATA_W + 1;
`else
  localparam int PW    = DATA_W;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run, a_wr, a_rd, b_rd;
  logic [DATA_W-1:0] b_word;
  logic [PW-1:0]     a_pin, b_pin, a_pout, b_pout;
  logic              a_rvalid, b_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end

  assign run           = (state == ST_RUN);
  assign bus.a_ready   = run;
  assign bus.b_ready   = run;
  assign bus.init_done = run;

  // Reset wins over a request presented on the same edge.
  assign a_wr = bus.a_valid && run && !reset && bus.a_we;
  assign a_rd = bus.a_valid && run && !reset && !bus.a_we;
  assign b_rd = bus.b_valid && run && !reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[cnt] <= '0;
      end else if (a_wr) begin
        for (int i = 0; i < NB; i++)
          if (bus.a_be[i]) mem[bus.a_addr][8*i +: 8] <= bus.a_wdata[8*i +: 8];
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] b_par;
  logic          a_perr_raw, b_perr_raw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        par[cnt] <= '0;
      end else if (a_wr) begin
        for (int i = 0; i < NB; i++)
          if (bus.a_be[i]) par[bus.a_addr][i] <= byte_parity(bus.a_wdata[8*i +: 8]);
      end
    end
  end
`endif

  // Port B sees a same-cycle port A write to its address (write-first).
  always_comb begin
    b_word = mem[bus.b_addr];
`ifdef RAM_PARITY_EN
    b_par      = par[bus.b_addr];
    a_perr_raw = 1'b0;
    b_perr_raw = 1'b0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (a_wr && (bus.a_addr == bus.b_addr) && bus.a_be[i]) begin
        b_word[8*i +: 8] = bus.a_wdata[8*i +: 8];
`ifdef RAM_PARITY_EN
        b_par[i] = byte_parity(bus.a_wdata[8*i +: 8]);
`endif
      end
    end
`ifdef RAM_PARITY_EN
    for (int i = 0; i < NB; i++) begin
      a_perr_raw = a_perr_raw | (byte_parity(mem[bus.a_addr][8*i +: 8]) != par[bus.a_addr][i]);
      b_perr_raw = b_perr_raw | (byte_parity(b_word[8*i +: 8]) != b_par[i]);
    end
`endif
  end

`ifdef RAM_PARITY_EN
  assign a_pin       = {a_perr_raw, mem[bus.a_addr]};
  assign b_pin       = {b_perr_raw, b_word};
  assign bus.a_rdata = a_pout[DATA_W-1:0];
  assign bus.b_rdata = b_pout[DATA_W-1:0];
  assign bus.a_perr  = a_rvalid & a_pout[DATA_W];
  assign bus.b_perr  = b_rvalid & b_pout[DATA_W];
`else
  assign a_pin       = mem[bus.a_addr];
  assign b_pin       = b_word;
  assign bus.a_rdata = a_pout;
  assign bus.b_rdata = b_pout;
`endif
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;

  ram_rd_pipe #(.W(PW), .LAT(RD_LAT)) u_pipe_a (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (a_rd),
    .in_dat  (a_pin),
    .out_vld (a_rvalid),
    .out_dat (a_pout)
  );

  ram_rd_pipe #(.W(PW), .LAT(RD_LAT)) u_pipe_b (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (b_rd),
    .in_dat  (b_pin),
    .out_vld (b_rvalid),
    .out_dat (b_pout)
  );

endmodule

// File: tb/tb_pipelined_dp_ram.sv
// Bench for pipelined_dp_ram: directed vector table, reset/clear sequences and random traffic
// checked against a word-array reference model with per-port expected-response queues.
module tb_pipelined_dp_ram;

  localparam int DW     = 32;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipelined_dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  pipelined_dp_ram #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] dat;
    bit          perr;
  } exp_t;

  typedef struct {
    bit          av;
    bit          awe;
    logic [3:0]  aad;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          bv;
    logic [3:0]  bad;
    logic [31:0] a_exp;
    logic [31:0] b_exp;
  } vec_t;

  exp_t        qa[$], qb[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_a = '0, last_b = '0;
  int          checks = 0, errors = 0, cyc = 0;
  bit          run = 1'b0;
  vec_t        tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outs();
    chk("a_ready", 32'(bus.a_ready), 32'(run));
    chk("b_ready", 32'(bus.b_ready), 32'(run));
    chk("init_done", 32'(bus.init_done), 32'(run));
    if (qa.size() > 0 && qa[0].due == cyc) begin
      chk("a_rvalid", 32'(bus.a_rvalid), 32'd1);
      chk("a_rdata", bus.a_rdata, qa[0].dat);
`ifdef RAM_PARITY_EN
      chk("a_perr", 32'(bus.a_perr), 32'(qa[0].perr));
`endif
      last_a = qa[0].dat;
      qa.delete(0);
    end else begin
      chk("a_rvalid_idle", 32'(bus.a_rvalid), 32'd0);
      chk("a_rdata_hold", bus.a_rdata, last_a);
`ifdef RAM_PARITY_EN
      chk("a_perr_idle", 32'(bus.a_perr), 32'd0);
`endif
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      chk("b_rvalid", 32'(bus.b_rvalid), 32'd1);
      chk("b_rdata", bus.b_rdata, qb[0].dat);
`ifdef RAM_PARITY_EN
      chk("b_perr", 32'(bus.b_perr), 32'(qb[0].perr));
`endif
      last_b = qb[0].dat;
      qb.delete(0);
    end else begin
      chk("b_rvalid_idle", 32'(bus.b_rvalid), 32'd0);
      chk("b_rdata_hold", bus.b_rdata, last_b);
`ifdef RAM_PARITY_EN
      chk("b_perr_idle", 32'(bus.b_perr), 32'd0);
`endif
    end
  endtask

  // One bus cycle; table-driven reads expect the hand-derived value, others the model.
  task automatic cycle(input bit av, input bit awe, input logic [3:0] aad, input logic [31:0] wd,
                       input logic [3:0] be, input bit bv, input logic [3:0] bad,
                       input bit use_exp, input logic [31:0] a_exp, input logic [31:0] b_exp);
    exp_t e;
    bus.a_valid = av;
    bus.a_we    = awe;
    bus.a_addr  = aad;
    bus.a_wdata = wd;
    bus.a_be    = be;
    bus.b_valid = bv;
    bus.b_addr  = bad;
    step();
    if (run) begin
      if (av && awe)
        for (int i = 0; i < 4; i++)
          if (be[i]) model[aad][8*i +: 8] = wd[8*i +: 8];
      if (av && !awe) begin
        e = '{cyc + RD_LAT - 1, use_exp ? a_exp : model[aad], 1'b0};
        qa.push_back(e);
      end
      if (bv) begin
        e = '{cyc + RD_LAT - 1, use_exp ? b_exp : model[bad], 1'b0};
        qb.push_back(e);
      end
    end
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_wait();
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      run = (k == DEPTH);
      check_outs();
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0; bus.a_be = '0;
    bus.b_valid = 0; bus.b_addr = '0;

    tbl[0] = '{1, 1, 4'd5, 32'hDEADBEEF, 4'hF, 0, 4'd0, 32'h0, 32'h0};
    tbl[1] = '{0, 0, 4'd0, 32'h0, 4'h0, 1, 4'd5, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{1, 1, 4'd7, 32'hFFFFFFFF, 4'hF, 0, 4'd0, 32'h0, 32'h0};
    tbl[3] = '{1, 1, 4'd7, 32'h11223344, 4'b0101, 0, 4'd0, 32'h0, 32'h0};
    tbl[4] = '{1, 0, 4'd7, 32'h0, 4'h0, 0, 4'd0, 32'hFF22FF44, 32'h0};
    tbl[5] = '{1, 1, 4'd3, 32'hA5A5A5A5, 4'hF, 1, 4'd3, 32'h0, 32'hA5A5A5A5};
    tbl[6] = '{1, 1, 4'd3, 32'h12345678, 4'h0, 1, 4'd3, 32'h0, 32'hA5A5A5A5};
    tbl[7] = '{1, 0, 4'd3, 32'h0, 4'h0, 1, 4'd5, 32'hA5A5A5A5, 32'hDEADBEEF};
    tbl[8] = '{1, 0, 4'd0, 32'h0, 4'h0, 1, 4'd15, 32'h0, 32'h0};

    // Reset state, then exactly DEPTH stalled cycles of clearing.
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs();
    end
    reset = 1'b0;
    clear_wait();

    // Every word reads back zero after the clear, on both ports back to back.
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 0, 4'(i), 0, 0, 1, 4'(DEPTH - 1 - i), 1, 32'h0, 32'h0);
    idle(RD_LAT + 1);

    foreach (tbl[i])
      cycle(tbl[i].av, tbl[i].awe, tbl[i].aad, tbl[i].wd, tbl[i].be,
            tbl[i].bv, tbl[i].bad, 1, tbl[i].a_exp, tbl[i].b_exp);
    idle(RD_LAT + 1);

    for (int n = 0; n < 400; n++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)),
            $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, DEPTH - 1)), 0, 0, 0);
    idle(RD_LAT + 1);

`ifdef RAM_PARITY_EN
    begin
      exp_t e;
      dut.mem[9] = dut.mem[9] ^ 32'h1;
      model[9]   = model[9] ^ 32'h1;
      bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 4'd9; bus.b_valid = 0;
      step();
      e = '{cyc + RD_LAT - 1, model[9], 1'b1};
      qa.push_back(e);
      check_outs();
      cycle(1, 0, 4'd8, 0, 0, 0, 0, 0, 0, 0);
      idle(RD_LAT + 1);
    end
`endif

    // Reset lands on the second of four back-to-back B reads.
    cycle(0, 0, 0, 0, 0, 1, 4'd1, 0, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      reset = 1'b1;
      bus.b_valid = 1;
      bus.b_addr  = 4'(i);
      step();
      run = 1'b0;
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
      check_outs();
    end
    reset = 1'b0;
    clear_wait();
    cycle(0, 0, 0, 0, 0, 1, 4'd5, 1, 32'h0, 32'h0);
    cycle(1, 0, 4'd7, 0, 0, 1, 4'd3, 1, 32'h0, 32'h0);
    idle(RD_LAT + 2);

    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d A and %0d B responses never arrived, expected 0", qa.size(), qb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
